// File: rtl/excess3_word_decoder_if.sv
// Digit-in / word-out handshake bundle for the excess-3 word decoder.
// The slave modport is the decoder's view; master is the producer/consumer side.
interface excess3_word_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              in_code;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] out_bcd;
  logic                    out_err;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_code,
    output out_valid,
    input  out_ready,
    output out_bcd,
    output out_err
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_code,
    input  out_valid,
    output out_ready,
    input  out_bcd,
    input  out_err
  );

endinterface

// File: rtl/excess3_word_decoder.sv
// Converts a stream of excess-3 digits into packed BCD words, most significant
// digit first, with a sticky per-word flag for illegal codes.
module excess3_word_decoder #(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  excess3_word_decoder_if.slave bus
);

  localparam int unsigned Width = 4 * NUM_DIGITS;
  localparam int unsigned CntW  = $clog2(NUM_DIGITS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StCollect, StOutput} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [Width-1:0] shift_q;
  logic [Width-1:0] bcd_q;
  logic            err_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic             accept;
  logic             code_illegal;
  logic [3:0]       digit;
  logic [Width-1:0] shift_next;

  always_comb begin
    accept       = bus.in_valid && in_ready_q;
    code_illegal = (bus.in_code < 4'h3) || (bus.in_code > 4'hC);
    digit        = code_illegal ? 4'h0 : (bus.in_code - 4'h3);
    // Shift form keeps NUM_DIGITS=1 legal (no negative slice bounds).
    shift_next   = (shift_q << 4) | Width'(digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      cnt_q       <= '0;
      shift_q     <= '0;
      bcd_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StCollect: begin
          if (accept) begin
            shift_q <= shift_next;
            err_q   <= err_q | code_illegal;
            if (cnt_q == LastCnt) begin
              bcd_q       <= shift_next;
              state_q     <= StOutput;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StOutput: begin
          if (bus.out_ready) begin
            state_q     <= StCollect;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StCollect;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bcd   = bcd_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_excess3_word_decoder.sv
// Bench for excess3_word_decoder: directed scenarios plus random traffic,
// all compared cycle by cycle against a digit-queue reference model.
module tb_excess3_word_decoder;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst;

  excess3_word_decoder_if #(.NUM_DIGITS(N)) bus ();

  excess3_word_decoder #(.NUM_DIGITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_out_valid;
  logic        m_err;
  logic [31:0] m_bcd;
  int          digs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [3:0] c, input logic ordy);
    int code;
    int word;
    code = int'(c);
    if (r) begin
      m_out_valid = 1'b0;
      m_err       = 1'b0;
      m_bcd       = '0;
      digs.delete();
    end else if (m_out_valid) begin
      if (ordy) begin
        m_out_valid = 1'b0;
        m_err       = 1'b0;
      end
    end else if (v) begin
      if (code >= 3 && code <= 12) begin
        digs.push_back(code - 3);
      end else begin
        digs.push_back(0);
        m_err = 1'b1;
      end
      if (digs.size() == N) begin
        word = 0;
        foreach (digs[i]) word = word * 16 + digs[i];
        m_bcd       = 32'(word);
        m_out_valid = 1'b1;
        digs.delete();
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at the next negedge.
  task automatic cycle(input logic r, input logic v, input logic [3:0] c, input logic ordy);
    rst           = r;
    bus.in_valid  = v;
    bus.in_code   = c;
    bus.out_ready = ordy;
    @(posedge clk);
    model_step(r, v, c, ordy);
    @(negedge clk);
    check("in_ready", 32'(bus.in_ready), 32'(!m_out_valid));
    check("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
    check("out_bcd", 32'(bus.out_bcd), m_bcd);
    if (m_out_valid) check("out_err", 32'(bus.out_err), 32'(m_err));
  endtask

  task automatic send_word(input logic [15:0] codes, input int gap);
    logic [3:0] c;
    for (int i = 3; i >= 0; i--) begin
      c = codes[i*4 +: 4];
      cycle(1'b0, 1'b1, c, 1'b1);
      for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 4'h0, 1'b1);
    end
  endtask

  logic [15:0] held;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_code   = 4'h0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check("reset_out_err", 32'(bus.out_err), 32'h0);
    check("reset_in_ready", 32'(bus.in_ready), 32'h1);

    // 1: basic word; out_valid the cycle after the 4th accept
    send_word(16'h4567, 0);
    check("t1_valid", 32'(bus.out_valid), 32'h1);
    check("t1_bcd", 32'(bus.out_bcd), 32'h1234);
    check("t1_err", 32'(bus.out_err), 32'h0);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
    check("t1_ready_back", 32'(bus.in_ready), 32'h1);

    // 2: legal boundary codes
    send_word(16'h3C3C, 0);
    check("t2_bcd", 32'(bus.out_bcd), 32'h0909);
    check("t2_err", 32'(bus.out_err), 32'h0);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);

    // 3: illegal codes, then error flag clears for the next word
    send_word(16'h4F62, 0);
    check("t3_bcd", 32'(bus.out_bcd), 32'h1030);
    check("t3_err", 32'(bus.out_err), 32'h1);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
    send_word(16'h8888, 0);
    check("t3b_bcd", 32'(bus.out_bcd), 32'h5555);
    check("t3b_err", 32'(bus.out_err), 32'h0);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);

    // 4: backpressure with changing codes offered
    send_word(16'h9876, 0);
    held = 16'h6543;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'(i + 4), 1'b0);
    check("t4_bcd_held", 32'(bus.out_bcd), 32'(held));
    check("t4_in_ready", 32'(bus.in_ready), 32'h0);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
    check("t4_released", 32'(bus.out_valid), 32'h0);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
    check("t4_single_xfer", 32'(bus.out_valid), 32'h0);

    // 5: reset mid-word discards the partial digits
    cycle(1'b0, 1'b1, 4'h4, 1'b1);
    cycle(1'b0, 1'b1, 4'h5, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    check("t5_valid_rst", 32'(bus.out_valid), 32'h0);
    send_word(16'h9ABC, 0);
    check("t5_bcd", 32'(bus.out_bcd), 32'h6789);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);

    // 6: idle gaps between digits
    send_word(16'h4567, 3);
    check("t6_bcd", 32'(bus.out_bcd), 32'h1234);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(63) == 0), 1'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
